seq_divide_arbiter: RTL

- Shares one seq_divide instance between NumReq independent requesters.
- Round-robin arbitration over valid/ready request channels; sequences the divider's start/finish protocol.
- Returns quotient, remainder and requester ID on a single valid/ready response channel.
- Sits between client units and the divider; the divider is instantiated alongside, not inside.

---
 rtl/seq_divide_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/seq_divide_arbiter.sv
// seq_divide_arbiter
// Shares one sequential divider between NumReq requesters. A round-robin
// arbiter picks one request per job. The block then runs the divider's
// start/finish handshake and returns the quotient, the remainder and the
// requester ID on a single valid/ready response channel.
//
// Optional feature (compile-time macro): SEQ_DIVIDE_ARB_DZ_BYPASS_EN
//   When this macro is defined, a request with a zero divisor does not use
//   the divider. It goes straight to the response with q = all ones, r = a
//   and dz = 1. When the macro is undefined, a zero divisor runs through the
//   divider like any other request, and dz is still reported.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   req_valid_i/req_ready_o per-requester request handshake (ready one-hot or 0)
//   req_a_i, req_b_i        packed dividends/divisors, requester k at slice k
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_id_o, rsp_q_o,      served requester, quotient, remainder,
//   rsp_r_o, rsp_dz_o       divisor-was-zero flag
//   div_a_o, div_b_o,       operands and start pulse to the divider
//   div_start_o
//   div_q_i, div_r_i,       result and completion pulse from the divider
//   div_finish_i
//   busy_o                  high whenever a job is in flight (state != IDLE)

module seq_divide_arbiter #(
  parameter int NumReq = 4,
  parameter int WidthA = 32,
  parameter int WidthB = 32,
  localparam int WidthId = $clog2(NumReq)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_valid_i,
  output logic [NumReq-1:0]        req_ready_o,
  input  logic [NumReq*WidthA-1:0] req_a_i,
  input  logic [NumReq*WidthB-1:0] req_b_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WidthId-1:0]       rsp_id_o,
  output logic [WidthA-1:0]        rsp_q_o,
  output logic [WidthB-1:0]        rsp_r_o,
  output logic                     rsp_dz_o,
  output logic [WidthA-1:0]        div_a_o,
  output logic [WidthB-1:0]        div_b_o,
  output logic                     div_start_o,
  input  logic [WidthA-1:0]        div_q_i,
  input  logic [WidthB-1:0]        div_r_i,
  input  logic                     div_finish_i,
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic [WidthId-1:0] ptr_q;
  logic [WidthId-1:0] cand;
  logic [WidthId-1:0] grant_idx;
  logic               grant_found;
  logic [NumReq-1:0]  grant_oh;
  logic [WidthA-1:0]  sel_a;
  logic [WidthB-1:0]  sel_b;
  logic               accept;

  logic [WidthA-1:0]  a_arr [NumReq];
  logic [WidthB-1:0]  b_arr [NumReq];

  // Modulo-NumReq add. The sum is reduced by hand because NumReq need not
  // be a power of two.
  function automatic logic [WidthId-1:0] wrap_add(input logic [WidthId-1:0] base,
                                                  input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NumReq) sum = sum - NumReq;
    return WidthId'(sum);
  endfunction

  // Unpack the flat operand buses so the granted slice can be selected by index.
  for (genvar k = 0; k < NumReq; k++) begin : g_unpack
    assign a_arr[k] = req_a_i[k*WidthA +: WidthA];
    assign b_arr[k] = req_b_i[k*WidthB +: WidthB];
  end

  // Round-robin scan. Start at the pointer and wrap, taking the first valid
  // requester. The scan runs every cycle, but the result is used only in IDLE.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = wrap_add(ptr_q, i);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_oh = NumReq'(1) << grant_idx;
  assign sel_a    = a_arr[grant_idx];
  assign sel_b    = b_arr[grant_idx];
  assign accept   = (state_q == S_IDLE) && grant_found;

  // Next state and combinational handshake outputs. Reset masks ready and
  // start in the same cycle, so nothing is accepted or launched while reset
  // is asserted.
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    div_start_o = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready_o = grant_oh;
`ifdef SEQ_DIVIDE_ARB_DZ_BYPASS_EN
          state_d = (sel_b == '0) ? S_RESP : S_ISSUE;
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        div_start_o = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (div_finish_i) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst_i) begin
      req_ready_o = '0;
      div_start_o = 1'b0;
      rsp_valid_o = 1'b0;
    end
  end

  assign busy_o = (state_q != S_IDLE);

  // State register and round-robin pointer. The pointer moves only on an
  // accepted request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) ptr_q <= wrap_add(grant_idx, 1);
    end
  end

  // Operand, ID and result registers.
  // Operands are captured at accept and held until the next accept, which
  // keeps them stable while the divider works.
  // The divider result is taken only in WAIT, so a finish pulse left over
  // from an aborted job cannot leak into the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_a_o  <= '0;
      div_b_o  <= '0;
      rsp_id_o <= '0;
      rsp_q_o  <= '0;
      rsp_r_o  <= '0;
      rsp_dz_o <= 1'b0;
    end else begin
      if (accept) begin
        div_a_o  <= sel_a;
        div_b_o  <= sel_b;
        rsp_id_o <= grant_idx;
        rsp_dz_o <= (sel_b == '0);
`ifdef SEQ_DIVIDE_ARB_DZ_BYPASS_EN
        if (sel_b == '0) begin
          rsp_q_o <= '1;
          rsp_r_o <= WidthB'(sel_a);
        end
`endif
      end
      if ((state_q == S_WAIT) && div_finish_i) begin
        rsp_q_o <= div_q_i;
        rsp_r_o <= div_r_i;
      end
    end
  end

endmodule
